// File: rtl/ram_word_master_if.sv
// Request/response and byte-RAM signal bundle for ram_word_master.
// req_be exists only when RAM_WORD_MASTER_BYTEMASK_EN is defined.
interface ram_word_master_if #(
  parameter int LOG_HEIGHT = 3
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // The initiator holds req_* stable while req_valid is high and not yet accepted;
  // rsp_valid is a single-cycle strobe with no back-pressure.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [LOG_HEIGHT+1:0] req_adr;
  logic [31:0]           req_wdata;
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
  logic [3:0]            req_be;
`endif
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [LOG_HEIGHT+1:0] mem_adr;
  logic                  mem_rwn;
  logic [7:0]            mem_bytein;
  logic [7:0]            mem_byteout;

  modport master (
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
    input  req_be,
`endif
    input  req_valid, req_write, req_adr, req_wdata, mem_byteout,
    output req_ready, rsp_valid, rsp_rdata, mem_adr, mem_rwn, mem_bytein
  );

  modport slave (
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
    output req_be,
`endif
    output req_valid, req_write, req_adr, req_wdata, mem_byteout,
    input  req_ready, rsp_valid, rsp_rdata, mem_adr, mem_rwn, mem_bytein
  );
endinterface

// File: rtl/ram_word_master.sv
// Sequences 32-bit word requests into four byte accesses on the byte RAM.
// Optional byte mask: define RAM_WORD_MASTER_BYTEMASK_EN.
module ram_word_master #(
  parameter int LOG_HEIGHT = 3,
  parameter int RD_LAT     = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  ram_word_master_if.master  bus,
  output logic [1:0]         dbg_state
);
  localparam int AW = LOG_HEIGHT + 2;
  localparam int DW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [DW-1:0]   dcnt;
  logic [AW-3:0]   base_hi;
  logic            wr;
  logic [31:0]     wdata;
  logic [3:0]      be;
  logic [31:0]     asm_word;
  logic [31:0]     byte_mask;
  logic [RD_LAT-1:0]      cap_vld;
  logic [RD_LAT-1:0][1:0] cap_idx;

  logic [3:0]      req_be_in;
  logic            accept;
  logic            issue_next;
  logic [1:0]      nxt_k;
  logic [AW-3:0]   nxt_hi;
  logic            nxt_wr;
  logic [31:0]     nxt_wdata;
  logic [3:0]      nxt_be;
  logic            unused_adr_lsb;

`ifdef RAM_WORD_MASTER_BYTEMASK_EN
  assign req_be_in = bus.req_be;
`else
  assign req_be_in = 4'hF;
`endif

  assign unused_adr_lsb = ^bus.req_adr[1:0];
  assign dbg_state      = state;
  assign accept         = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign byte_mask      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // Byte access driven in the next cycle; on acceptance it comes straight from the request.
  always_comb begin
    issue_next = accept || ((state == ACCESS) && (cnt != 2'd3));
    nxt_k      = accept ? 2'd0 : cnt + 2'd1;
    nxt_hi     = accept ? bus.req_adr[AW-1:2] : base_hi;
    nxt_wr     = accept ? bus.req_write : wr;
    nxt_wdata  = accept ? bus.req_wdata : wdata;
    nxt_be     = accept ? req_be_in : be;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dcnt           <= '0;
      base_hi        <= '0;
      wr             <= 1'b0;
      wdata          <= '0;
      be             <= '0;
      asm_word       <= '0;
      cap_vld        <= '0;
      cap_idx        <= '0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.mem_adr    <= '0;
      bus.mem_rwn    <= 1'b1;
      bus.mem_bytein <= '0;
    end else begin
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.mem_adr    <= '0;
      bus.mem_rwn    <= 1'b1;
      bus.mem_bytein <= '0;

      case (state)
        IDLE: begin
          if (accept) begin
            base_hi <= bus.req_adr[AW-1:2];
            wr      <= bus.req_write;
            wdata   <= bus.req_wdata;
            be      <= req_be_in;
            cnt     <= 2'd0;
            state   <= ACCESS;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 2'd3) begin
            if (wr) begin
              state         <= DONE;
              bus.rsp_valid <= 1'b1;
            end else begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(RD_LAT - 1)) begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (issue_next) begin
        bus.mem_adr    <= {nxt_hi, nxt_k};
        bus.mem_rwn    <= !(nxt_wr && nxt_be[nxt_k]);
        bus.mem_bytein <= nxt_wr ? nxt_wdata[8*nxt_k +: 8] : 8'h00;
      end

      // Each read byte's index travels RD_LAT cycles to meet its data on mem_byteout.
      cap_vld[0] <= (state == ACCESS) && !wr;
      cap_idx[0] <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        cap_vld[i] <= cap_vld[i-1];
        cap_idx[i] <= cap_idx[i-1];
      end

      if (cap_vld[RD_LAT-1]) begin
        if (cap_idx[RD_LAT-1] == 2'd3) begin
          bus.rsp_rdata <= {bus.mem_byteout, asm_word[23:0]} & byte_mask;
        end else begin
          asm_word[8*cap_idx[RD_LAT-1] +: 8] <= bus.mem_byteout;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_word_master.sv
// Bench for ram_word_master: byte-RAM model, word-level reference memory,
// directed cases followed by randomized requests.
module tb_ram_word_master;
  localparam int LH     = 3;
  localparam int RD_LAT = 1;
  localparam int AW     = LH + 2;
  localparam int NBYTES = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [1:0] dbg_state;
  ram_word_master_if #(.LOG_HEIGHT(LH)) bus ();

  ram_word_master #(.LOG_HEIGHT(LH), .RD_LAT(RD_LAT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- attached byte RAM ----------------
  logic [7:0] init_val [NBYTES];
  logic [7:0] ram_arr  [NBYTES];
  logic [7:0] rd_pipe  [RD_LAT];
  logic       ram_filled = 1'b0;

  always @(posedge clock) begin
    if (!ram_filled) begin
      for (int i = 0; i < NBYTES; i++) ram_arr[i] <= init_val[i];
      ram_filled <= 1'b1;
    end else if (!bus.mem_rwn) begin
      ram_arr[bus.mem_adr] <= bus.mem_bytein;
    end
    rd_pipe[0] <= ram_arr[bus.mem_adr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_byteout = rd_pipe[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          n_vec;
  int          n_err;
  int          last_rsp_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE.
  task automatic do_req(input logic wr, input logic [AW-1:0] adr, input logic [31:0] wd,
                        input logic [3:0] be, input bit keep);
    int            lat;
    int            waited;
    bit            acc;
    logic [AW-1:0] base;
    logic [31:0]   word;
    base = {adr[AW-1:2], 2'b00};
    lat  = wr ? 5 : 5 + RD_LAT;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_adr   = adr;
    bus.req_wdata = wd;
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
    bus.req_be    = be;
`endif
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 20) begin
      if (bus.req_ready) acc = 1'b1;
      else begin
        @(negedge clock);
        waited++;
      end
    end
    check("accept", 32'(acc), 32'd1);
    if (!acc) begin
      bus.req_valid = 1'b0;
      return;
    end
    if (wr) begin
      for (int k = 0; k < 4; k++) if (be[k]) ref_mem[base + AW'(k)] = wd[8*k +: 8];
    end else begin
      word = '0;
      for (int k = 0; k < 4; k++) if (be[k]) word[8*k +: 8] = ref_mem[base + AW'(k)];
      exp_q.push_back(word);
    end
    @(posedge clock);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clock);
      if (n == 1 && !keep) bus.req_valid = 1'b0;
      if (n <= 4) begin
        check("mem_adr", 32'(bus.mem_adr), 32'(base + AW'(n - 1)));
        check("mem_rwn", 32'(bus.mem_rwn), 32'(!(wr && be[n-1])));
        check("mem_bytein", 32'(bus.mem_bytein), wr ? 32'(wd[8*(n-1) +: 8]) : 32'd0);
      end else begin
        check("quiet_rwn", 32'(bus.mem_rwn), 32'd1);
        check("quiet_adr", 32'(bus.mem_adr), 32'd0);
      end
      check("req_ready", 32'(bus.req_ready), 32'(n == lat + 1));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(n == lat));
      if (n == lat) begin
        if (wr) check("rdata_hold", bus.rsp_rdata, last_rd);
        else if (exp_q.size() > 0) begin
          word = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, word);
          last_rd = word;
        end
        last_rsp_cyc = cyc;
      end
    end
  endtask

  // Reset asserted while byte 2 of a write is on the bus.
  task automatic reset_mid_write(input logic [AW-1:0] base, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_adr   = base;
    bus.req_wdata = wd;
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
    bus.req_be    = 4'hF;
`endif
    check("rst_pre_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_k2_adr", 32'(bus.mem_adr), 32'(base + AW'(2)));
    reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rwn", 32'(bus.mem_rwn), 32'd1);
    check("rst_adr", 32'(bus.mem_adr), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    ref_mem[base]         = wd[7:0];
    ref_mem[base + AW'(1)] = wd[15:8];
    last_rd = '0;
    repeat (3) begin
      @(negedge clock);
      check("rst_hold_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_release_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- main stimulus ----------------
  initial begin
    int t1;
    logic [3:0] rbe;
    for (int i = 0; i < NBYTES; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end
    n_vec = 0;
    n_err = 0;
    last_rd = '0;
    last_rsp_cyc = 0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_adr   = '0;
    bus.req_wdata = '0;
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
    bus.req_be    = 4'h0;
`endif
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    check("reset_adr", 32'(bus.mem_adr), 32'd0);
    check("reset_rwn", 32'(bus.mem_rwn), 32'd1);
    check("reset_bytein", 32'(bus.mem_bytein), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Directed cases
    do_req(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 1'b0);
    do_req(1'b0, 5'h04, 32'h0, 4'hF, 1'b0);
    do_req(1'b0, 5'h07, 32'h0, 4'hF, 1'b0);
    do_req(1'b1, 5'h1C, 32'h01234567, 4'hF, 1'b0);
    do_req(1'b0, 5'h1E, 32'h0, 4'hF, 1'b0);

    // Held req_valid across two writes
    do_req(1'b1, 5'h00, $urandom, 4'hF, 1'b1);
    t1 = last_rsp_cyc;
    do_req(1'b1, 5'h10, $urandom, 4'hF, 1'b0);
    check("b2b_spacing", 32'(last_rsp_cyc - t1), 32'd6);

    reset_mid_write(5'h08, 32'hCAFEF00D);
    do_req(1'b0, 5'h08, 32'h0, 4'hF, 1'b0);

`ifdef RAM_WORD_MASTER_BYTEMASK_EN
    do_req(1'b1, 5'h08, 32'h11223344, 4'hF, 1'b0);
    do_req(1'b1, 5'h08, 32'hAABBCCDD, 4'b0101, 1'b0);
    do_req(1'b0, 5'h08, 32'h0, 4'hF, 1'b0);
    do_req(1'b0, 5'h08, 32'h0, 4'b0011, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
`ifdef RAM_WORD_MASTER_BYTEMASK_EN
      rbe = 4'($urandom_range(0, 15));
`else
      rbe = 4'hF;
`endif
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, NBYTES - 1)), $urandom, rbe,
             ($urandom_range(0, 3) == 0));
    end
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("final_quiet", 32'(bus.rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_word_master.md
Name: ram_word_master

Overview:
- Initiator for the byte-addressable RAM.
- Accepts 32-bit word read/write requests over a valid/ready handshake and sequences them into four single-byte RAM accesses on the RAM's bytein/byteout/adr/rwn interface.
- Reassembles read bytes into a word and returns it with a one-cycle response strobe.
- Sits between the datapath's load/store logic and the RAM array.

Parameters:
- LOG_HEIGHT, 3, RAM holds 2**LOG_HEIGHT words; byte address width is LOG_HEIGHT+2. Must match the attached RAM.
- RD_LAT, 1, cycles from a read byte's issue cycle to the cycle its data is valid on mem_byteout. Legal range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = word write, 0 = word read.
- req_adr  in  LOG_HEIGHT+2  byte address of the word; bits [1:0] ignored.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion strobe, for reads and writes.
- rsp_rdata  out  32  assembled read word.
- mem_adr  out  LOG_HEIGHT+2  byte address to the RAM.
- mem_rwn  out  1  1 = read, 0 = write.
- mem_bytein  out  8  write byte to the RAM.
- mem_byteout  in  8  read byte from the RAM.

Behaviour:
- Reset values (async on reset_n low, held while low):
  - req_ready=0 while reset_n is low; 1 from the first clock edge after release.
  - rsp_valid=0, rsp_rdata=0.
  - mem_adr=0, mem_rwn=1, mem_bytein=0.
  - FSM in IDLE; byte counter=0.
- FSM states: IDLE, ACCESS, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - mem_rwn=1, mem_adr=0, mem_bytein=0 (idle reads are harmless to the RAM).
  - On req_valid&&req_ready: latch base={req_adr[top:2],2'b00}, req_write and req_wdata; counter=0; go to ACCESS.
  - Request inputs are ignored in every other state.
- ACCESS (4 cycles, counter k=0..3):
  - mem_adr=base+k. Low bits come from the counter, so the address never wraps out of the word.
  - Write: mem_rwn=0, mem_bytein=req_wdata[8k+7:8k].
  - Read: mem_rwn=1, mem_bytein=0.
  - Byte ordering is little-endian: byte at base+k maps to bits [8k+7:8k].
  - After k=3, a write goes to DONE and a read goes to DRAIN.
- DRAIN (reads only, RD_LAT cycles):
  - mem_rwn=1, mem_adr=0.
  - The read byte issued in ACCESS cycle k is captured from mem_byteout exactly RD_LAT cycles later. Captures therefore overlap ACCESS and DRAIN.
  - After RD_LAT cycles, go to DONE.
- DONE (1 cycle):
  - rsp_valid=1.
  - For reads, rsp_rdata is updated with the assembled word in the same cycle.
  - Go to IDLE.
- Latency, acceptance edge to rsp_valid high:
  - write: 5 cycles.
  - read: 5+RD_LAT cycles.
- rsp_rdata holds its value until the next read completes; writes never alter it.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after DONE, so there is a 1-cycle bubble minimum. A held req_valid is accepted there.
- Reset mid-operation: the access aborts immediately and no rsp_valid is produced. A partially written word remains partially written in the RAM.
- Address at the top word (e.g. 0x1C when LOG_HEIGHT=3) covers bytes 0x1C..0x1F; there is no wrap.

Optional Feature:
- Macro: RAM_WORD_MASTER_BYTEMASK_EN.
- Defined:
  - Adds input req_be[3:0], latched at acceptance.
  - On writes, a byte with be[k]=0 still takes its ACCESS cycle but drives mem_rwn=1, so no write occurs. Latency is unchanged.
  - On reads, rsp_rdata bytes with be[k]=0 are forced to 0x00.
- Undefined: port absent; all four bytes are always accessed, equivalent to be=4'hF.

Test Plan:
- Write 0xDEADBEEF to req_adr=0x04 -> mem_adr 4,5,6,7 with mem_rwn=0 and mem_bytein EF,BE,AD,DE; rsp_valid exactly 5 cycles after acceptance.
- Read req_adr=0x04 after the above (RD_LAT=1 RAM model) -> mem_adr 4..7 with mem_rwn=1; rsp_rdata=0xDEADBEEF with rsp_valid at cycle 6.
- Read req_adr=0x07 -> treated as base 0x04, same 0xDEADBEEF. Write 0x01234567 to 0x1C -> mem_adr 1C..1F; no access to 0x00.
- req_valid held high across two writes -> req_ready low from acceptance through DONE; second request accepted in the following IDLE cycle; two rsp_valid pulses 6 cycles apart.
- reset_n low during ACCESS k=2 of a write -> immediately req_ready=0, mem_rwn=1, mem_adr=0, no rsp_valid; after release bytes 0,1 hold new data and bytes 2,3 hold old data.
- With RAM_WORD_MASTER_BYTEMASK_EN, write 0xAABBCCDD with be=4'b0101 to 0x08 over prior 0x11223344 -> read back 0x11BB33DD. With be=4'b0011 the read returns 0x000033DD.
